// File: rtl/tt_sweep_pkg.sv
// Shared types and row/bit mapping helpers for the truth-table sweep stage.
package tt_sweep_pkg;

    localparam int MAX_N_IN = 6;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_SETTLE,
        ST_DONE
    } state_t;

    // Gate input _0 is the row MSB, so stim is the bit-reversed row index.
    function automatic logic [MAX_N_IN-1:0] row_to_stim(input logic [MAX_N_IN-1:0] row,
                                                        input int unsigned n_in);
        logic [MAX_N_IN-1:0] s;
        s = '0;
        for (int k = 0; k < MAX_N_IN; k++) begin
            if (k < int'(n_in)) s[k] = row[int'(n_in) - 1 - k];
        end
        return s;
    endfunction

    // Row 0 lands in the MSB of the truth-table word.
    function automatic int unsigned tt_index(input int unsigned row, input int unsigned n_in);
        return (32'd1 << n_in) - 32'd1 - row;
    endfunction

endpackage

// File: rtl/tt_sweep_capture_timer.sv
// Loadable settle down-counter; zero flag marks the sampling cycle of a row.
module tt_settle_timer #(
    parameter int SETTLE = 2
) (
    input  logic clk,
    input  logic rst_n,
    input  logic load,
    output logic zero
);

    localparam int TW = ($clog2(SETTLE + 1) < 1) ? 1 : $clog2(SETTLE + 1);

    logic [TW-1:0] count;

    // NOTE: sequential state is updated with <= so every flop sees pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count <= '0;
        end else if (load) begin
            count <= TW'(SETTLE);
        end else if (count != '0) begin
            count <= count - TW'(1);
        end
    end

    assign zero = (count == '0);

endmodule

// File: rtl/tt_sweep_capture.sv
// Walks a combinational gate through every input row and captures its truth table.
// Optional TT_SWEEP_MISMATCH_EN adds mismatch_cnt and first_bad_row outputs.
module tt_sweep_capture
    import tt_sweep_pkg::*;
#(
    parameter int N_IN = 4,
    parameter int SETTLE = 2,
    parameter logic [(1<<N_IN)-1:0] EXPECT_TT = 16'h3060
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  start,
    output logic [N_IN-1:0]       stim,
    input  logic                  resp,
    output logic                  busy,
    output logic                  done,
    output logic [(1<<N_IN)-1:0]  tt,
    output logic                  match
`ifdef TT_SWEEP_MISMATCH_EN
    ,
    output logic [N_IN:0]         mismatch_cnt,
    output logic [N_IN-1:0]       first_bad_row
`endif
);

    localparam int TT_W = 1 << N_IN;
    localparam logic [N_IN:0] LAST_ROW = (N_IN+1)'(TT_W - 1);

    state_t              state;
    logic [N_IN:0]       row;
    logic [N_IN:0]       row_inc;
    logic [N_IN-1:0]     idx;
    logic [TT_W-1:0]     tt_sampled;
    logic [MAX_N_IN-1:0] stim_wide;
    logic                timer_load;
    logic                timer_zero;

    // NOTE: every always_comb output gets a default first so no latch is inferred.
    always_comb begin
        row_inc     = row + (N_IN+1)'(1);
        idx         = N_IN'(tt_index(32'(row), N_IN));
        tt_sampled  = tt;
        tt_sampled[idx] = resp;
        stim_wide   = row_to_stim(MAX_N_IN'(row_inc), N_IN);
        timer_load  = ((state == ST_IDLE) && start) ||
                      ((state == ST_SETTLE) && timer_zero && (row != LAST_ROW));
    end

    tt_settle_timer #(.SETTLE(SETTLE)) u_timer (
        .clk   (clk),
        .rst_n (rst_n),
        .load  (timer_load),
        .zero  (timer_zero)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= ST_IDLE;
            row   <= '0;
            stim  <= '0;
            busy  <= 1'b0;
            done  <= 1'b0;
            tt    <= '0;
            match <= 1'b0;
`ifdef TT_SWEEP_MISMATCH_EN
            mismatch_cnt  <= '0;
            first_bad_row <= '0;
`endif
        end else begin
            case (state)
                ST_IDLE: begin
                    if (start) begin
                        row   <= '0;
                        stim  <= '0;
                        tt    <= '0;
                        busy  <= 1'b1;
                        state <= ST_SETTLE;
`ifdef TT_SWEEP_MISMATCH_EN
                        mismatch_cnt  <= '0;
                        first_bad_row <= '0;
`endif
                    end
                end
                ST_SETTLE: begin
                    if (timer_zero) begin
                        tt <= tt_sampled;
`ifdef TT_SWEEP_MISMATCH_EN
                        if (resp != EXPECT_TT[idx]) begin
                            mismatch_cnt <= mismatch_cnt + (N_IN+1)'(1);
                            if (mismatch_cnt == '0) first_bad_row <= row[N_IN-1:0];
                        end
`endif
                        if (row == LAST_ROW) begin
                            // The final bit is folded in here so match sees the complete word.
                            match <= (tt_sampled == EXPECT_TT);
                            done  <= 1'b1;
                            busy  <= 1'b0;
                            stim  <= '0;
                            state <= ST_DONE;
                        end else begin
                            row  <= row_inc;
                            stim <= stim_wide[N_IN-1:0];
                        end
                    end
                end
                ST_DONE: begin
                    done  <= 1'b0;
                    state <= ST_IDLE;
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule
